// File: rtl/s_res_sched.sv
// S-register result scheduler: delay-indexed timing chain that fires the S write
// port on the cycle a result lands, plus a per-register pending-write scoreboard.
module s_res_sched #(
  parameter int NUM_REGS  = 8,
  parameter int REG_W     = 3,
  parameter int DELAY_W   = 4,
  parameter int MAX_DELAY = 15,
  parameter int SRC_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_issue,
  input  logic                i_dest_en,
  input  logic [REG_W-1:0]    i_dest,
  input  logic [DELAY_W-1:0]  i_delay,
  input  logic [SRC_W-1:0]    i_src,
  input  logic                i_flush,
  input  logic [REG_W-1:0]    i_rd_j,
  input  logic                i_rd_j_en,
  input  logic [REG_W-1:0]    i_rd_k,
  input  logic                i_rd_k_en,
  output logic                o_issue_ok,
  output logic                o_bad_delay,
  output logic                o_hazard,
  output logic                o_s_wr_en,
  output logic [REG_W-1:0]    o_s_wr_addr,
  output logic [SRC_W-1:0]    o_s_wr_src,
  output logic [NUM_REGS-1:0] o_busy
);

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dest;
    logic [SRC_W-1:0] src;
  } slot_t;

  // r_slot[k] writes k cycles from now; invalid slots always hold all-zero fields
  slot_t [MAX_DELAY-1:0] r_slot;
  logic  [NUM_REGS-1:0]  r_busy;

  logic                w_delay_ok;
  logic                w_slot_taken;
  logic                w_dest_busy;
  logic                w_sched_ok;
  logic                w_accept;
  logic [NUM_REGS-1:0] w_wr_mask;
  logic [NUM_REGS-1:0] w_set_mask;

  always_comb begin
    w_delay_ok   = (i_delay != '0) && (32'(i_delay) <= MAX_DELAY);
    // the top position (delay == MAX_DELAY) has no slot above it, so it is always free
    w_slot_taken = 1'b0;
    for (int k = 1; k < MAX_DELAY; k++)
      if (32'(i_delay) == k) w_slot_taken = r_slot[k].vld;
    w_dest_busy  = r_busy[i_dest];
    w_sched_ok   = w_delay_ok && !w_dest_busy && !w_slot_taken;
    o_bad_delay  = i_dest_en && !w_delay_ok;
    o_issue_ok   = !i_flush && (!i_dest_en || w_sched_ok);
    w_accept     = i_issue && i_dest_en && o_issue_ok;
    o_hazard     = (i_rd_j_en && r_busy[i_rd_j]) ||
                   (i_rd_k_en && r_busy[i_rd_k]) ||
                   (i_dest_en && w_dest_busy);
    w_wr_mask    = '0;
    if (r_slot[0].vld) w_wr_mask[r_slot[0].dest] = 1'b1;
    w_set_mask   = '0;
    if (w_accept) w_set_mask[i_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_slot <= '0;
      r_busy <= '0;
    end else begin
      for (int k = 0; k < MAX_DELAY-1; k++) r_slot[k] <= r_slot[k+1];
      r_slot[MAX_DELAY-1] <= '0;
      for (int k = 0; k < MAX_DELAY; k++)
        if (w_accept && (32'(i_delay) == k+1)) r_slot[k] <= '{vld: 1'b1, dest: i_dest, src: i_src};
      // busy is held through the write cycle, so a same-cycle reissue is refused
      r_busy <= (r_busy & ~w_wr_mask) | w_set_mask;
    end
  end

  assign o_s_wr_en   = r_slot[0].vld;
  assign o_s_wr_addr = r_slot[0].dest;
  assign o_s_wr_src  = r_slot[0].src;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_s_res_sched.sv
// Scoreboard bench for s_res_sched: issues push expected writes, a negedge monitor checks them.
module tb_s_res_sched;
  logic       clk = 0;
  logic       rst, i_issue, i_dest_en, i_flush, i_rd_j_en, i_rd_k_en;
  logic [2:0] i_dest, i_rd_j, i_rd_k;
  logic [3:0] i_delay;
  logic [4:0] i_src;
  logic       o_issue_ok, o_bad_delay, o_hazard, o_s_wr_en;
  logic [2:0] o_s_wr_addr;
  logic [4:0] o_s_wr_src;
  logic [7:0] o_busy;

  s_res_sched dut (
    .clk(clk), .rst(rst), .i_issue(i_issue), .i_dest_en(i_dest_en), .i_dest(i_dest),
    .i_delay(i_delay), .i_src(i_src), .i_flush(i_flush), .i_rd_j(i_rd_j),
    .i_rd_j_en(i_rd_j_en), .i_rd_k(i_rd_k), .i_rd_k_en(i_rd_k_en),
    .o_issue_ok(o_issue_ok), .o_bad_delay(o_bad_delay), .o_hazard(o_hazard),
    .o_s_wr_en(o_s_wr_en), .o_s_wr_addr(o_s_wr_addr), .o_s_wr_src(o_s_wr_src),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [2:0] addr;
    logic [4:0] src;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write, on its cycle
  always @(negedge clk) begin
    if (o_s_wr_en) begin
      exp_t e;
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write cyc=%0d addr=%0d src=%0d", cyc, o_s_wr_addr, o_s_wr_src);
      end else begin
        e = q.pop_front();
        if (e.due != cyc || e.addr !== o_s_wr_addr || e.src !== o_s_wr_src) begin
          n_fail++;
          $display("FAIL write cyc=%0d addr=%0d src=%0d exp cyc=%0d addr=%0d src=%0d",
                   cyc, o_s_wr_addr, o_s_wr_src, e.due, e.addr, e.src);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp(input int due, input logic [2:0] a, input logic [4:0] s);
    exp_t e;
    int pos;
    e.due = due; e.addr = a; e.src = s;
    pos = q.size();
    for (int i = 0; i < q.size(); i++)
      if (q[i].due > due) begin pos = i; break; end
    q.insert(pos, e);
  endtask

  task automatic drop_after(input int c);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due > c) q.delete(i);
  endtask

  task automatic do_issue(input logic [2:0] d, input logic [3:0] dl, input logic [4:0] s,
                          input logic exp_ok, input logic exp_bad, input logic fl);
    i_issue = 1; i_dest_en = 1; i_dest = d; i_delay = dl; i_src = s; i_flush = fl;
    #1;
    chk("issue_ok", o_issue_ok, exp_ok);
    chk("bad_delay", o_bad_delay, exp_bad);
    if (fl) drop_after(cyc);
    if (exp_ok) push_exp(cyc + int'(dl), d, s);
    @(posedge clk); #1;
    i_issue = 0; i_dest_en = 0; i_flush = 0;
  endtask

  initial begin
    int t;
    rst = 1; i_issue = 0; i_dest_en = 0; i_dest = 0; i_delay = 0; i_src = 0; i_flush = 0;
    i_rd_j = 0; i_rd_j_en = 0; i_rd_k = 0; i_rd_k_en = 0;
    idle(3);
    chk("rst_busy", o_busy, 8'h00);
    chk("rst_wr_en", o_s_wr_en, 0);
    chk("rst_addr", o_s_wr_addr, 0);
    chk("rst_src", o_s_wr_src, 0);
    rst = 0;
    idle(2);

    // single issue: busy window and write cycle
    do_issue(3, 4, 5, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin chk("t1_busy", o_busy, 8'h08); idle(1); end
    chk("t1_busy_clr", o_busy, 8'h00);
    i_rd_j = 3; i_rd_j_en = 1; #1;
    chk("t1_no_hazard", o_hazard, 0);
    i_rd_j_en = 0;
    idle(2);

    // port collision then retry
    do_issue(1, 5, 7, 1, 0, 0);
    do_issue(2, 4, 9, 0, 0, 0);
    chk("t2_busy_after_reject", o_busy, 8'h02);
    do_issue(2, 4, 9, 1, 0, 0);
    chk("t2_busy_both", o_busy, 8'h06);
    idle(8);

    // hazard window and write-cycle reissue
    do_issue(6, 3, 2, 1, 0, 0);
    i_rd_k = 6; i_rd_k_en = 1;
    for (int i = 0; i < 2; i++) begin #1; chk("t3_hazard", o_hazard, 1); idle(1); end
    #1; chk("t3_hazard_wr", o_hazard, 1);
    chk("t3_wr_cycle", o_s_wr_en, 1);
    do_issue(6, 2, 4, 0, 0, 0);
    i_rd_k_en = 0;
    do_issue(6, 2, 4, 1, 0, 0);
    i_rd_k_en = 1; #1;
    chk("t3_hazard_again", o_hazard, 1);
    i_rd_k_en = 0;
    idle(5);

    // delay boundaries
    do_issue(0, 0, 1, 0, 1, 0);
    chk("t4_no_state", o_busy, 8'h00);
    do_issue(4, 15, 3, 1, 0, 0);
    chk("t4_busy", o_busy, 8'h10);
    idle(16);
    chk("t4_busy_clr", o_busy, 8'h00);

    // flush with three pending and a concurrent issue
    do_issue(1, 3, 11, 1, 0, 0);
    do_issue(2, 5, 12, 1, 0, 0);
    do_issue(3, 6, 13, 1, 0, 0);
    chk("t5_busy_pend", o_busy, 8'h0e);
    do_issue(5, 2, 14, 0, 0, 1);
    chk("t5_busy_flushed", o_busy, 8'h00);
    idle(10);

    // reset mid-flight
    do_issue(0, 4, 21, 1, 0, 0);
    do_issue(7, 6, 22, 1, 0, 0);
    rst = 1; drop_after(cyc);
    idle(1);
    rst = 0;
    chk("t6_wr_en", o_s_wr_en, 0);
    chk("t6_busy", o_busy, 8'h00);
    idle(12);

    t = q.size();
    chk("pending_left", t, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
